reg_file_arbiter: RTL and testbench
===================================

Name: reg_file_arbiter

Overview:
- Sits between the core pipeline, the debug transport and the 32x32 synchronous register file.
- Owns the register file's single write port and two read ports, and multiplexes core and debug accesses onto them.
- Hides the register file's one-cycle read latency and its old-data-on-collision behaviour by forwarding same-cycle writes.
- Guarantees debug access forward progress through a starvation counter that stalls the core.

Parameters:
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register address bits
- MAX_WAIT, 8, cycles a pending debug request may be blocked before the core is stalled (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_rd_en  in  1  core read request, both read addresses valid
- core_r0_addr, core_r1_addr  in  ADDR_WIDTH  core read addresses
- core_wr_en  in  1  core write request
- core_w_addr  in  ADDR_WIDTH  core write address
- core_w_data  in  DATA_WIDTH  core write data
- core_stall  out  1  core must hold its request; request is not performed
- core_rd_valid  out  1  core_r0_data/core_r1_data valid this cycle
- core_r0_data, core_r1_data  out  DATA_WIDTH  core read data, forwarded
- dbg_req  in  1  debug request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_WIDTH  debug register address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_WIDTH  debug read data; valid with dbg_ack, held until the next read completes
- rf_wr_en  out  1  register file write enable
- rf_w_addr  out  ADDR_WIDTH  register file write address
- rf_w_data  out  DATA_WIDTH  register file write data
- rf_r0_addr, rf_r1_addr  out  ADDR_WIDTH  register file read addresses
- rf_r0_data, rf_r1_data  in  DATA_WIDTH  register file read data, one cycle after address

Behaviour:
- Reset (async, immediate):
  - state=IDLE, wait counter=0.
  - core_stall, core_rd_valid, dbg_ack = 0; dbg_rdata = 0.
  - Forwarding registers cleared.
  - Register file contents untouched.
- rf_* address/data outputs are combinational muxes of the selected requester; rf_wr_en is gated by the grant.
- State machine (states IDLE, DBG_WR, DBG_RD, DBG_RD_WAIT, DBG_ACK):
  - IDLE: core owns the ports.
    - dbg_req with core idle (!core_rd_en & !core_wr_en) -> DBG_WR if dbg_we, else DBG_RD.
    - dbg_req with core active -> counter increments. When counter == MAX_WAIT: core_stall=1 and core is blocked; next state is DBG_WR/DBG_RD.
  - DBG_WR: rf_wr_en=1, rf_w_addr=dbg_addr, rf_w_data=dbg_wdata, core_stall=1 -> DBG_ACK.
  - DBG_RD: rf_r0_addr=dbg_addr, core_stall=1 -> DBG_RD_WAIT.
  - DBG_RD_WAIT: capture rf_r0_data (with forwarding) into dbg_rdata, core_stall=1 -> DBG_ACK.
  - DBG_ACK: dbg_ack=1 for one cycle, counter=0, core_stall=0 -> IDLE. dbg_req may stay high this cycle; it is not re-sampled until IDLE.
- Core accesses in IDLE without stall:
  - Write and read pass straight through.
  - core_rd_valid is asserted the cycle after core_rd_en.
  - Data returns rf data except when forwarded.
- While core_stall=1:
  - rf_wr_en is driven only by debug.
  - Core reads issue nothing; core_rd_valid=0 the following cycle.
- Forwarding:
  - Register the previous cycle's (rf_wr_en, rf_w_addr, rf_w_data) and read addresses.
  - On the return cycle, if the prior write was enabled and its address equals the prior read address and is nonzero, substitute the written data. Per port; applies to debug reads too.
- x0:
  - Writes to address 0 are passed to the register file, which ignores them.
  - Reads of x0 return 0 and are never forwarded.
  - A debug write to x0 still acks.
- Debug write latency: ack 2 cycles after grant. Debug read latency: ack 3 cycles after grant.
- Simultaneous dbg_req rising and counter == MAX_WAIT: debug is granted, with no double increment.
- Reset asserted mid-transaction: the transaction is aborted, no ack is issued, and the debug side must re-request.

Test Plan:
- Core idle; debug write x5=0xDEADBEEF, then debug read x5 -> write ack 2 cycles after req; read ack 3 cycles after grant with dbg_rdata=0xDEADBEEF.
- Core writes x3=0x1234 and reads x3 in the same cycle -> next cycle core_rd_valid=1 and core_r0_data=0x1234 (forwarded). Same sequence to x0 -> 0.
- Core continuously active with dbg_req held -> core_stall rises after exactly MAX_WAIT=8 blocked cycles; no rf write from the core while stalled; debug completes; stall drops after dbg_ack.
- Stalled core asserts core_wr_en x7=0x55 throughout the stall -> x7 unchanged by the core until the stall is released; then x7=0x55.
- Reset asserted during DBG_RD_WAIT -> all outputs 0 immediately, no dbg_ack, state IDLE; register contents preserved (read of a prior value matches).
- Debug write x0=0xFFFFFFFF -> ack issued; subsequent read of x0 returns 0.

Source files
------------

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares a 32x32 synchronous register file between the core
// pipeline and the debug transport.
//   - Core side: two read ports + one write port, core_stall back-pressure,
//     read data returned one cycle later with same-cycle write forwarding.
//   - Debug side: req/ack handshake, single read or write per request.
//   - Starvation counter: after MAX_WAIT blocked cycles the core is stalled so
//     a pending debug request always completes.
//   - rf_*: drives the register file ports (rf_r*_data arrive one cycle late).
module reg_file_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_rd_en,
  input  logic [ADDR_WIDTH-1:0] core_r0_addr,
  input  logic [ADDR_WIDTH-1:0] core_r1_addr,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_w_addr,
  input  logic [DATA_WIDTH-1:0] core_w_data,
  output logic                  core_stall,
  output logic                  core_rd_valid,
  output logic [DATA_WIDTH-1:0] core_r0_data,
  output logic [DATA_WIDTH-1:0] core_r1_data,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_w_addr,
  output logic [DATA_WIDTH-1:0] rf_w_data,
  output logic [ADDR_WIDTH-1:0] rf_r0_addr,
  output logic [ADDR_WIDTH-1:0] rf_r1_addr,
  input  logic [DATA_WIDTH-1:0] rf_r0_data,
  input  logic [DATA_WIDTH-1:0] rf_r1_data
);

  localparam int unsigned CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    DBG_WR,
    DBG_RD,
    DBG_RD_WAIT,
    DBG_ACK
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_nxt;
  logic                  core_active;
  logic                  starved;
  logic                  core_grant;

  // Previous-cycle port activity, used to patch the collision case.
  logic                  prev_wr_en;
  logic [ADDR_WIDTH-1:0] prev_w_addr;
  logic [DATA_WIDTH-1:0] prev_w_data;
  logic [ADDR_WIDTH-1:0] prev_r0_addr;
  logic [ADDR_WIDTH-1:0] prev_r1_addr;
  logic [DATA_WIDTH-1:0] fwd_r0;
  logic [DATA_WIDTH-1:0] fwd_r1;

  assign core_active = core_rd_en | core_wr_en;
  assign starved     = (wait_cnt == CNT_WIDTH'(MAX_WAIT));

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state, grant and handshake decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    core_stall   = 1'b0;
    core_grant   = 1'b0;
    dbg_ack      = 1'b0;
    case (state)
      IDLE: begin
        if (starved) core_stall = 1'b1;
        else         core_grant = 1'b1;
        if (!dbg_req) begin
          wait_cnt_nxt = '0;
        end else if (!core_active || starved) begin
          // Grant without counting, so a starved grant never double-increments.
          state_nxt = dbg_we ? DBG_WR : DBG_RD;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_WIDTH'(1);
        end
      end
      DBG_WR: begin
        core_stall = 1'b1;
        state_nxt  = DBG_ACK;
      end
      DBG_RD: begin
        core_stall = 1'b1;
        state_nxt  = DBG_RD_WAIT;
      end
      DBG_RD_WAIT: begin
        core_stall = 1'b1;
        state_nxt  = DBG_ACK;
      end
      DBG_ACK: begin
        dbg_ack      = 1'b1;
        core_grant   = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register file port muxing; the core write is dropped unless granted.
  always_comb begin
    rf_wr_en   = core_grant & core_wr_en;
    rf_w_addr  = core_w_addr;
    rf_w_data  = core_w_data;
    rf_r0_addr = core_r0_addr;
    rf_r1_addr = core_r1_addr;
    if (state == DBG_WR) begin
      rf_wr_en  = 1'b1;
      rf_w_addr = dbg_addr;
      rf_w_data = dbg_wdata;
    end
    if (state == DBG_RD) rf_r0_addr = dbg_addr;
  end

  // Return-cycle data: x0 reads as zero, a same-cycle write wins over the array.
  always_comb begin
    fwd_r0 = rf_r0_data;
    fwd_r1 = rf_r1_data;
    if (prev_r0_addr == '0)
      fwd_r0 = '0;
    else if (prev_wr_en && (prev_w_addr == prev_r0_addr))
      fwd_r0 = prev_w_data;
    if (prev_r1_addr == '0)
      fwd_r1 = '0;
    else if (prev_wr_en && (prev_w_addr == prev_r1_addr))
      fwd_r1 = prev_w_data;
  end

  assign core_r0_data = fwd_r0;
  assign core_r1_data = fwd_r1;

  // Forwarding history, core read valid and debug read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_wr_en    <= 1'b0;
      prev_w_addr   <= '0;
      prev_w_data   <= '0;
      prev_r0_addr  <= '0;
      prev_r1_addr  <= '0;
      core_rd_valid <= 1'b0;
      dbg_rdata     <= '0;
    end else begin
      prev_wr_en    <= rf_wr_en;
      prev_w_addr   <= rf_w_addr;
      prev_w_data   <= rf_w_data;
      prev_r0_addr  <= rf_r0_addr;
      prev_r1_addr  <= rf_r1_addr;
      core_rd_valid <= core_grant & core_rd_en;
      if (state == DBG_RD_WAIT) dbg_rdata <= fwd_r0;
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: directed + randomized bench for reg_file_arbiter.
// Includes a behavioural 32x32 synchronous register file (old data on
// read/write collision) and an architectural register model in which a read
// sees any write issued in the same cycle.
module tb_reg_file_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_rd_en;
  logic [AW-1:0] core_r0_addr, core_r1_addr;
  logic          core_wr_en;
  logic [AW-1:0] core_w_addr;
  logic [DW-1:0] core_w_data;
  logic          core_stall;
  logic          core_rd_valid;
  logic [DW-1:0] core_r0_data, core_r1_data;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          rf_wr_en;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic [AW-1:0] rf_r0_addr, rf_r1_addr;
  logic [DW-1:0] rf_r0_data, rf_r1_data;

  reg_file_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_rd_en   (core_rd_en),
    .core_r0_addr (core_r0_addr),
    .core_r1_addr (core_r1_addr),
    .core_wr_en   (core_wr_en),
    .core_w_addr  (core_w_addr),
    .core_w_data  (core_w_data),
    .core_stall   (core_stall),
    .core_rd_valid(core_rd_valid),
    .core_r0_data (core_r0_data),
    .core_r1_data (core_r1_data),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_ack      (dbg_ack),
    .dbg_rdata    (dbg_rdata),
    .rf_wr_en     (rf_wr_en),
    .rf_w_addr    (rf_w_addr),
    .rf_w_data    (rf_w_data),
    .rf_r0_addr   (rf_r0_addr),
    .rf_r1_addr   (rf_r1_addr),
    .rf_r0_data   (rf_r0_data),
    .rf_r1_data   (rf_r1_data)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write (x0 ignored), one-cycle read, old data on collision.
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_wr_en && rf_w_addr != '0) rf_mem[rf_w_addr] <= rf_w_data;
    rf_r0_data <= rf_mem[rf_r0_addr];
    rf_r1_data <= rf_mem[rf_r1_addr];
  end

  // Architectural register contents as the core/debug should observe them.
  logic [DW-1:0] gold [32] = '{default: '0};

  int n_pass  = 0;
  int n_total = 0;

  logic          exp_valid;
  logic [DW-1:0] exp_r0, exp_r1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One unstalled core cycle: check last cycle's read, then issue a new request.
  task automatic core_step(input logic rd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input string tag);
    cyc();
    chk({tag, "_valid"}, DW'(core_rd_valid), DW'(exp_valid));
    if (exp_valid) begin
      chk({tag, "_r0"}, core_r0_data, exp_r0);
      chk({tag, "_r1"}, core_r1_data, exp_r1);
    end
    core_rd_en   = rd;
    core_r0_addr = a0;
    core_r1_addr = a1;
    core_wr_en   = wr;
    core_w_addr  = wa;
    core_w_data  = wd;
    if (wr && wa != '0) gold[wa] = wd;
    exp_valid = rd;
    exp_r0    = gold[a0];
    exp_r1    = gold[a1];
  endtask

  // Debug transfer with the core idle: checks ack latency, pulse width, read data.
  task automatic dbg_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input string tag);
    int lat;
    bit done;
    cyc();
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      cyc();
      lat++;
      if (dbg_ack) done = 1'b1;
    end
    dbg_req = 1'b0;
    dbg_we  = 1'b0;
    chk({tag, "_lat"}, DW'(lat), DW'(we ? 2 : 3));
    if (we) begin
      if (addr != '0) gold[addr] = wdata;
    end else begin
      chk({tag, "_rdata"}, dbg_rdata, gold[addr]);
    end
    cyc();
    chk({tag, "_ack_pulse"}, DW'(dbg_ack), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    core_rd_en   = 1'b0;
    core_r0_addr = '0;
    core_r1_addr = '0;
    core_wr_en   = 1'b0;
    core_w_addr  = '0;
    core_w_data  = '0;
    dbg_req      = 1'b0;
    dbg_we       = 1'b0;
    dbg_addr     = '0;
    dbg_wdata    = '0;
    exp_valid    = 1'b0;
    exp_r0       = '0;
    exp_r1       = '0;

    // Reset state.
    cyc();
    cyc();
    chk("rst_stall",    DW'(core_stall),    DW'(0));
    chk("rst_rd_valid", DW'(core_rd_valid), DW'(0));
    chk("rst_ack",      DW'(dbg_ack),       DW'(0));
    chk("rst_rdata",    dbg_rdata,          DW'(0));
    chk("rst_rf_wr",    DW'(rf_wr_en),      DW'(0));
    rst = 1'b0;

    // Debug write then read of x5 with the core idle.
    dbg_xfer(1'b1, AW'(5), 32'hDEADBEEF, "dbg_wr_x5");
    dbg_xfer(1'b0, AW'(5), 32'h0,        "dbg_rd_x5");

    // Core same-cycle write/read forwarding, then x0 handling.
    core_step(1'b1, AW'(3), AW'(5), 1'b1, AW'(3), 32'h1234,     "fwd_x3");
    core_step(1'b1, AW'(0), AW'(3), 1'b1, AW'(0), 32'hFFFF0000, "fwd_x0");
    core_step(1'b0, AW'(0), AW'(0), 1'b0, AW'(0), 32'h0,        "fwd_done");
    core_step(1'b0, AW'(0), AW'(0), 1'b0, AW'(0), 32'h0,        "fwd_idle");

    // Starvation: core reads x7 every cycle while debug reads x7.
    dbg_xfer(1'b1, AW'(7), 32'hAA, "dbg_wr_x7");
    cyc();
    core_rd_en   = 1'b1;
    core_r0_addr = AW'(7);
    core_r1_addr = AW'(5);
    dbg_req      = 1'b1;
    dbg_we       = 1'b0;
    dbg_addr     = AW'(7);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) cyc();
      chk($sformatf("starve_stall_%0d", k), DW'(core_stall), DW'(k >= MW && k <= MW + 2));
      chk($sformatf("starve_ack_%0d", k),   DW'(dbg_ack),    DW'(k == MW + 3));
      chk($sformatf("starve_valid_%0d", k), DW'(core_rd_valid),
          DW'((k >= 1 && k <= MW) || k == MW + 4));
      if (k >= 1 && k <= MW) chk($sformatf("starve_r0_%0d", k), core_r0_data, 32'hAA);
      if (k == MW) begin
        // Stalled core now also holds a write to x7; it must not land yet.
        core_wr_en  = 1'b1;
        core_w_addr = AW'(7);
        core_w_data = 32'h55;
      end
      if (k < MW + 4) chk($sformatf("starve_rf_wr_%0d", k), DW'(rf_wr_en), DW'(k == MW + 3));
      if (k == MW + 3) begin
        chk("starve_dbg_rdata", dbg_rdata, 32'hAA);
        dbg_req = 1'b0;
        gold[7] = 32'h55;
      end
      if (k == MW + 4) begin
        chk("starve_post_r0", core_r0_data, 32'h55);
        chk("starve_post_r1", core_r1_data, 32'hDEADBEEF);
        core_rd_en = 1'b0;
        core_wr_en = 1'b0;
      end
    end
    exp_valid = 1'b0;
    dbg_xfer(1'b0, AW'(7), 32'h0, "dbg_rd_x7");

    // Reset during DBG_RD_WAIT aborts the read without an ack.
    cyc();
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = AW'(5);
    cyc();
    chk("abort_stall_rd", DW'(core_stall), DW'(1));
    cyc();
    chk("abort_stall_wait", DW'(core_stall), DW'(1));
    chk("abort_rdata_held", dbg_rdata, 32'h55);
    #1 rst = 1'b1;
    #1;
    chk("abort_stall", DW'(core_stall),    DW'(0));
    chk("abort_ack",   DW'(dbg_ack),       DW'(0));
    chk("abort_rdata", dbg_rdata,          DW'(0));
    chk("abort_valid", DW'(core_rd_valid), DW'(0));
    dbg_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("abort_no_ack_%0d", k), DW'(dbg_ack), DW'(0));
    end
    dbg_xfer(1'b0, AW'(5), 32'h0, "abort_rd_x5");

    // Debug write to x0 still acks; x0 keeps reading zero.
    dbg_xfer(1'b1, AW'(0), 32'hFFFFFFFF, "dbg_wr_x0");
    dbg_xfer(1'b0, AW'(0), 32'h0,        "dbg_rd_x0");

    // Random core traffic against the architectural model.
    for (int i = 0; i < 300; i++) begin
      core_step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                "rnd_core");
    end
    core_step(1'b0, AW'(0), AW'(0), 1'b0, AW'(0), 32'h0, "rnd_core_end");
    core_step(1'b0, AW'(0), AW'(0), 1'b0, AW'(0), 32'h0, "rnd_core_idle");

    // Random debug transfers with the core idle.
    for (int i = 0; i < 30; i++) begin
      dbg_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom), "rnd_dbg");
    end

    // Core sweep of all registers to cross-check debug writes.
    for (int a = 0; a < 32; a += 2) begin
      core_step(1'b1, AW'(a), AW'(a + 1), 1'b0, AW'(0), 32'h0, "sweep");
    end
    core_step(1'b0, AW'(0), AW'(0), 1'b0, AW'(0), 32'h0, "sweep_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
